// File: rtl/coffee_vend_if.sv
// Front-end/dispenser bundle for the coffee vending controller, plus debug
// visibility of the FSM state and the stock levels.
interface coffee_vend_if #(
   parameter int LEVEL_W = 8,
   parameter int QTY_W   = 2,
   parameter int CRED_W  = 8
);
   // Every input strobe (coin_valid, start, cancel, refill_valid) qualifies its
   // data for exactly one rising edge. There is no ready: coins and refills are
   // always taken, and start/cancel are dropped unless the controller is idle.
   logic              coin_valid;
   logic [CRED_W-1:0] coin_val;
   logic              start;
   logic [QTY_W-1:0]  milk_qty;
   logic [QTY_W-1:0]  sugar_qty;
   logic              cancel;
   logic              refill_valid;
   logic [2:0]        refill_sel;
   logic [LEVEL_W-1:0] refill_amt;

   logic              busy;
   logic [2:0]        stage;
   logic              coffee_ready;
   logic              fault;
   logic [2:0]        fault_code;
   logic              change_valid;
   logic [CRED_W-1:0] change_amt;
   logic [CRED_W-1:0] credit;
   logic [4:0]        low_stock;

   logic [3:0]                 state_dbg;
   logic [4:0][LEVEL_W-1:0]    level_dbg;

   modport master (
      output coin_valid, coin_val, start, milk_qty, sugar_qty, cancel,
             refill_valid, refill_sel, refill_amt,
      input  busy, stage, coffee_ready, fault, fault_code, change_valid,
             change_amt, credit, low_stock, state_dbg, level_dbg
   );

   modport slave (
      input  coin_valid, coin_val, start, milk_qty, sugar_qty, cancel,
             refill_valid, refill_sel, refill_amt,
      output busy, stage, coffee_ready, fault, fault_code, change_valid,
             change_amt, credit, low_stock, state_dbg, level_dbg
   );
endinterface

// File: rtl/coffee_vend_ctrl.sv
// Coffee vending controller: credit keeping, stock check, timed dispense
// sequence CUP->WATER->COFFEE->MILK->SUGAR, change return and stock tracking.
module coffee_vend_ctrl #(
   parameter int LEVEL_W     = 8,
   parameter int INIT_LEVEL  = 0,
   parameter int LOW_THRESH  = 4,
   parameter int QTY_W       = 2,
   parameter int STEP_CYCLES = 4,
   parameter int CRED_W      = 8,
   parameter int PRICE       = 10
) (
   input  logic          clk,
   input  logic          rst,
   coffee_vend_if.slave  bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_CHECK, S_CUP, S_WATER, S_COFFEE, S_MILK, S_SUGAR, S_DONE, S_FAULT
   } state_e;

   localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_CYCLES - 1);
   localparam logic [CRED_W-1:0]  PRICE_C   = CRED_W'(PRICE);
   localparam logic [LEVEL_W-1:0] INIT_C    = LEVEL_W'(INIT_LEVEL);
   localparam logic [LEVEL_W-1:0] LOW_C     = LEVEL_W'(LOW_THRESH);
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

   state_e             state_q;
   logic [STEP_W-1:0]  step_q;
   logic [QTY_W-1:0]   unit_q, milk_q, sugar_q;
   logic [CRED_W-1:0]  credit_q, change_amt_q;
   logic [2:0]         stage_q, fault_code_q;
   logic               ready_q, fault_q, change_valid_q;
   logic [LEVEL_W-1:0] level_q [5];
   logic [LEVEL_W-1:0] level_d [5];

   logic [CRED_W:0]    credit_ext;
   logic [CRED_W-1:0]  credit_sum;
   logic               unit_last, unit_more;
   logic [4:0]         dec;
   logic [2:0]         check_code;
   state_e             disp_next;

   function automatic logic [2:0] stage_of(state_e s);
      case (s)
         S_CUP:    return 3'd1;
         S_WATER:  return 3'd2;
         S_COFFEE: return 3'd3;
         S_MILK:   return 3'd4;
         S_SUGAR:  return 3'd5;
         default:  return 3'd0;
      endcase
   endfunction

   always_comb begin
      credit_ext = {1'b0, credit_q} + (bus.coin_valid ? {1'b0, bus.coin_val} : '0);
      credit_sum = credit_ext[CRED_W] ? '1 : credit_ext[CRED_W-1:0];
      unit_last  = (step_q == STEP_LAST);
      unit_more  = ((state_q == S_MILK)  && (unit_q != milk_q  - QTY_W'(1))) ||
                   ((state_q == S_SUGAR) && (unit_q != sugar_q - QTY_W'(1)));
      dec = '0;
      if (unit_last) begin
         case (state_q)
            S_CUP:    dec[0] = 1'b1;
            S_WATER:  dec[1] = 1'b1;
            S_COFFEE: dec[2] = 1'b1;
            S_MILK:   dec[3] = 1'b1;
            S_SUGAR:  dec[4] = 1'b1;
            default:  dec = '0;
         endcase
      end
      if (credit_q < PRICE_C)                    check_code = 3'd1;
      else if (level_q[0] == '0)                 check_code = 3'd2;
      else if (level_q[1] == '0)                 check_code = 3'd3;
      else if (level_q[2] == '0)                 check_code = 3'd4;
      else if (level_q[3] < LEVEL_W'(milk_q))    check_code = 3'd5;
      else if (level_q[4] < LEVEL_W'(sugar_q))   check_code = 3'd6;
      else                                       check_code = 3'd0;
      // Zero-quantity ingredients are skipped entirely rather than visited.
      case (state_q)
         S_CUP:    disp_next = S_WATER;
         S_WATER:  disp_next = S_COFFEE;
         S_COFFEE: disp_next = (milk_q != '0) ? S_MILK :
                               ((sugar_q != '0) ? S_SUGAR : S_DONE);
         S_MILK:   disp_next = (sugar_q != '0) ? S_SUGAR : S_DONE;
         default:  disp_next = S_DONE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         step_q         <= '0;
         unit_q         <= '0;
         milk_q         <= '0;
         sugar_q        <= '0;
         credit_q       <= '0;
         change_amt_q   <= '0;
         stage_q        <= 3'd0;
         fault_code_q   <= 3'd0;
         ready_q        <= 1'b0;
         fault_q        <= 1'b0;
         change_valid_q <= 1'b0;
      end else begin
         ready_q        <= 1'b0;
         fault_q        <= 1'b0;
         change_valid_q <= 1'b0;
         credit_q       <= credit_sum;
         case (state_q)
            S_IDLE: begin
               if (bus.cancel) begin
                  if (credit_q != '0) begin
                     change_valid_q <= 1'b1;
                     change_amt_q   <= credit_q;
                     credit_q       <= bus.coin_valid ? bus.coin_val : '0;
                  end
               end else if (bus.start) begin
                  milk_q  <= bus.milk_qty;
                  sugar_q <= bus.sugar_qty;
                  state_q <= S_CHECK;
               end
            end
            S_CHECK: begin
               fault_code_q <= check_code;
               if (check_code != 3'd0) begin
                  fault_q <= 1'b1;
                  state_q <= S_FAULT;
               end else begin
                  credit_q <= credit_sum - PRICE_C;
                  step_q   <= '0;
                  unit_q   <= '0;
                  state_q  <= S_CUP;
                  stage_q  <= stage_of(S_CUP);
               end
            end
            S_CUP, S_WATER, S_COFFEE, S_MILK, S_SUGAR: begin
               step_q <= unit_last ? '0 : step_q + STEP_W'(1);
               if (unit_last) begin
                  if (unit_more) begin
                     unit_q <= unit_q + QTY_W'(1);
                  end else begin
                     unit_q  <= '0;
                     state_q <= disp_next;
                     stage_q <= stage_of(disp_next);
                     // Change is announced on entry so it is visible during DONE.
                     if (disp_next == S_DONE) begin
                        ready_q <= 1'b1;
                        if (credit_sum != '0) begin
                           change_valid_q <= 1'b1;
                           change_amt_q   <= credit_sum;
                        end
                     end
                  end
               end
            end
            S_DONE: begin
               credit_q <= bus.coin_valid ? bus.coin_val : '0;
               state_q  <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Refill saturates first, then the same-cycle dispense decrement applies.
   always_comb begin
      for (int i = 0; i < 5; i++) begin
         logic [LEVEL_W:0]   add_ext;
         logic [LEVEL_W-1:0] lvl_sat;
         add_ext = {1'b0, level_q[i]} +
                   ((bus.refill_valid && bus.refill_sel == 3'(i)) ? {1'b0, bus.refill_amt} : '0);
         lvl_sat = add_ext[LEVEL_W] ? LEVEL_MAX : add_ext[LEVEL_W-1:0];
         level_d[i] = lvl_sat - LEVEL_W'(dec[i]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 5; i++) level_q[i] <= INIT_C;
      end else begin
         for (int i = 0; i < 5; i++) level_q[i] <= level_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         bus.low_stock[i] = (level_q[i] < LOW_C);
         bus.level_dbg[i] = level_q[i];
      end
   end

   assign bus.busy         = (state_q != S_IDLE);
   assign bus.stage        = stage_q;
   assign bus.coffee_ready = ready_q;
   assign bus.fault        = fault_q;
   assign bus.fault_code   = fault_code_q;
   assign bus.change_valid = change_valid_q;
   assign bus.change_amt   = change_amt_q;
   assign bus.credit       = credit_q;
   assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_coffee_vend_ctrl.sv
// Bench for coffee_vend_ctrl: directed scenarios plus random coin/refill/order
// traffic checked against a transaction-level model of credit and stock.
module tb_coffee_vend_ctrl;
  localparam int LEVEL_W = 8;
  localparam int QTY_W   = 2;
  localparam int STEP    = 4;
  localparam int CRED_W  = 8;
  localparam int PRICE   = 10;
  localparam int LMAX    = 255;
  localparam int CMAX    = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  coffee_vend_if #(.LEVEL_W(LEVEL_W), .QTY_W(QTY_W), .CRED_W(CRED_W)) bus ();

  coffee_vend_ctrl #(
    .LEVEL_W(LEVEL_W), .INIT_LEVEL(0), .LOW_THRESH(4), .QTY_W(QTY_W),
    .STEP_CYCLES(STEP), .CRED_W(CRED_W), .PRICE(PRICE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int m_level[5];
  int m_credit;
  logic [2:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    logic [4:0] low;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s_level%0d", tag, i), bus.level_dbg[i], m_level[i]);
      low[i] = (m_level[i] < 4);
    end
    check({tag, "_low"}, bus.low_stock, low);
    check({tag, "_credit"}, bus.credit, m_credit);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) m_level[i] = 0;
    m_credit = 0;
  endtask

  task automatic drive_coin(input int v);
    bus.coin_valid = 1'b1;
    bus.coin_val = CRED_W'(v);
    step();
    bus.coin_valid = 1'b0;
    m_credit = (m_credit + v > CMAX) ? CMAX : m_credit + v;
  endtask

  task automatic drive_refill(input int sel, input int amt);
    bus.refill_valid = 1'b1;
    bus.refill_sel = 3'(sel);
    bus.refill_amt = LEVEL_W'(amt);
    step();
    bus.refill_valid = 1'b0;
    if (sel < 5) m_level[sel] = (m_level[sel] + amt > LMAX) ? LMAX : m_level[sel] + amt;
  endtask

  task automatic drive_cancel();
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    check("cancel_change_valid", bus.change_valid, (m_credit > 0));
    if (m_credit > 0) check("cancel_change_amt", bus.change_amt, m_credit);
    m_credit = 0;
    check("cancel_credit", bus.credit, 0);
  endtask

  // One order from start to idle; rf_amt>0 refills sugar in the last sugar cycle.
  task automatic run_order(input int m, input int s, input int rf_amt);
    int code, n, lat, cyc, rf_cyc, chg;
    int units[5];
    if (m_credit < PRICE)         code = 1;
    else if (m_level[0] < 1)      code = 2;
    else if (m_level[1] < 1)      code = 3;
    else if (m_level[2] < 1)      code = 4;
    else if (m_level[3] < m)      code = 5;
    else if (m_level[4] < s)      code = 6;
    else                          code = 0;
    bus.milk_qty = QTY_W'(m);
    bus.sugar_qty = QTY_W'(s);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("order_busy", bus.busy, 1);
    if (code != 0) begin
      check("check_stage", bus.stage, 0);
      step();
      check("fault_pulse", bus.fault, 1);
      check("fault_code", bus.fault_code, code);
      step();
      check("fault_done", bus.fault, 0);
      check_state("after_fault");
      return;
    end
    units = '{1, 1, 1, m, s};
    n = 3 + m + s;
    lat = 2 + STEP * n;
    rf_cyc = (rf_amt > 0 && s > 0) ? 1 + STEP * n : -1;
    exp_q.delete();
    exp_q.push_back(3'd0);
    for (int v = 0; v < 5; v++)
      for (int u = 0; u < units[v] * STEP; u++) exp_q.push_back(3'(v + 1));
    cyc = 1;
    while (bus.coffee_ready !== 1'b1 && cyc <= lat + 4) begin
      check($sformatf("stage_c%0d", cyc), bus.stage, (exp_q.size() > 0) ? exp_q.pop_front() : 3'd7);
      if (cyc == rf_cyc) begin
        bus.refill_valid = 1'b1;
        bus.refill_sel = 3'd4;
        bus.refill_amt = LEVEL_W'(rf_amt);
      end
      step();
      bus.refill_valid = 1'b0;
      cyc++;
    end
    check("ready_seen", bus.coffee_ready, 1);
    check("latency", cyc, lat);
    check("stages_left", exp_q.size(), 0);
    check("done_stage", bus.stage, 0);
    chg = m_credit - PRICE;
    check("done_change_valid", bus.change_valid, (chg > 0));
    if (chg > 0) check("done_change_amt", bus.change_amt, chg);
    m_credit = 0;
    for (int v = 0; v < 4; v++) m_level[v] -= units[v];
    if (rf_cyc > 0)
      m_level[4] = ((m_level[4] - (s - 1) + rf_amt > LMAX) ? LMAX : m_level[4] - (s - 1) + rf_amt) - 1;
    else
      m_level[4] -= s;
    step();
    check("ready_pulse_end", bus.coffee_ready, 0);
    check_state("after_order");
  endtask

  initial begin
    int seen;
    bus.coin_valid = 1'b0; bus.coin_val = '0; bus.start = 1'b0;
    bus.milk_qty = '0; bus.sugar_qty = '0; bus.cancel = 1'b0;
    bus.refill_valid = 1'b0; bus.refill_sel = '0; bus.refill_amt = '0;
    for (int i = 0; i < 5; i++) m_level[i] = 0;
    m_credit = 0;
    #2;
    check("rst_busy", bus.busy, 0);
    check("rst_stage", bus.stage, 0);
    check("rst_ready", bus.coffee_ready, 0);
    check("rst_fault", bus.fault, 0);
    check("rst_fault_code", bus.fault_code, 0);
    check("rst_change_valid", bus.change_valid, 0);
    check("rst_change_amt", bus.change_amt, 0);
    check_state("rst");
    step();
    rst = 1'b1;

    for (int i = 0; i < 5; i++) drive_refill(i, 20);
    check_state("filled");
    drive_coin(10);
    run_order(1, 2, 0);

    drive_coin(5);
    run_order(0, 0, 0);
    drive_cancel();

    apply_reset();
    drive_refill(0, 20); drive_refill(1, 20); drive_refill(2, 20);
    drive_refill(3, 1);  drive_refill(4, 20);
    drive_coin(12);
    run_order(2, 0, 0);
    drive_cancel();

    drive_coin(15);
    run_order(0, 0, 0);

    apply_reset();
    drive_refill(0, 20); drive_refill(1, 20); drive_refill(2, 20);
    drive_refill(3, 20); drive_refill(4, 5);
    drive_coin(10);
    run_order(0, 1, 3);

    drive_refill(0, 250 - m_level[0]);
    drive_refill(0, 255);
    check_state("saturate");

    apply_reset();
    drive_refill(4, 3);
    check_state("low_set");
    drive_refill(4, 1);
    check_state("low_clear");
    drive_refill(7, 9);
    check_state("sel_ignored");

    drive_coin(200);
    drive_coin(100);
    check_state("credit_sat");
    drive_cancel();

    for (int i = 0; i < 5; i++) drive_refill(i, $urandom_range(2, 8));
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0, 1: drive_coin($urandom_range(0, 12));
        2: drive_refill($urandom_range(0, 7), $urandom_range(0, 6));
        3: drive_cancel();
        default: begin
          int m, s;
          m = $urandom_range(0, 3);
          s = $urandom_range(0, 3);
          run_order(m, s, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 9) : 0);
        end
      endcase
      check_state($sformatf("rand%0d", it));
    end

    for (int i = 0; i < 5; i++) drive_refill(i, 10);
    drive_coin(10);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    seen = 0;
    for (int c = 0; c < 30 && seen == 0; c++) begin
      if (bus.stage == 3'd3) seen = 1;
      else step();
    end
    check("coffee_stage_seen", seen, 1);
    check("coffee_busy", bus.busy, 1);
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) m_level[i] = 0;
    m_credit = 0;
    check("abort_stage", bus.stage, 0);
    check("abort_change", bus.change_valid, 0);
    check_state("abort");
    step();
    rst = 1'b1;
    step();
    check_state("post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
